// File: rtl/alu_seq_pkg.sv
//==============================================================================
// Module  : alu_seq_pkg
// Purpose : Shared types and constants for the wide ALU sequencer: ALU word
//           width, ALU op encoding and the sequencer state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int ALU_W = 64;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_OP_AND = 2'b00;
  localparam alu_op_t ALU_OP_OR  = 2'b01;
  localparam alu_op_t ALU_OP_ADD = 2'b10;
  // SUB inverts B inside the ALU, so the caller supplies cin=1.
  localparam alu_op_t ALU_OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_word_mux.sv
//==============================================================================
// Module  : alu_seq_word_mux
// Purpose : Combinational selector returning 64-bit word idx_i of the two
//           multi-word operands.
// Ports   : a_i, b_i    - WORDS*64-bit operands
//           idx_i       - word index (0 = least significant word)
//           a_word_o    - selected word of a_i
//           b_word_o    - selected word of b_i
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_seq_word_mux
  import alu_seq_pkg::*;
#(
  parameter int WORDS = 2,
  parameter int IDX_W = 1
) (
  input  logic [WORDS*ALU_W-1:0] a_i,
  input  logic [WORDS*ALU_W-1:0] b_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [ALU_W-1:0]       a_word_o,
  output logic [ALU_W-1:0]       b_word_o
);

  // One-hot compare per word; an out-of-range index yields zero.
  always_comb begin
    a_word_o = '0;
    b_word_o = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_i == IDX_W'(w)) begin
        a_word_o = a_i[w*ALU_W +: ALU_W];
        b_word_o = b_i[w*ALU_W +: ALU_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_wide_sequencer.sv
//==============================================================================
// Module  : alu_wide_sequencer
// Purpose : Runs one WORDS*64-bit add/sub/logic operation on an external
//           64-bit ALU, one word per cycle, LSW first, chaining carry-out of
//           each word into carry-in of the next, and returns the collected
//           result over a valid/ready response channel.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           req_valid_i/req_ready_o  - request handshake
//           req_a_i, req_b_i         - WORDS*64-bit operands
//           req_cin_i, req_op_i      - word-0 carry-in, ALU op
//           resp_valid_o/resp_ready_i- response handshake
//           resp_s_o, resp_cout_o    - result and final carry-out
//           alu_a_o, alu_b_o, alu_cin_o, alu_op_o - drive to the 64-bit ALU
//           alu_s_i, alu_cout_i      - combinational result from the ALU
// Config  : ALU_SEQ_B2B_EN - when defined, a new request may be accepted on
//           the same edge the response is taken, skipping the IDLE cycle.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [WORDS*ALU_W-1:0] req_a_i,
  input  logic [WORDS*ALU_W-1:0] req_b_i,
  input  logic                   req_cin_i,
  input  logic [1:0]             req_op_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [WORDS*ALU_W-1:0] resp_s_o,
  output logic                   resp_cout_o,
  output logic [ALU_W-1:0]       alu_a_o,
  output logic [ALU_W-1:0]       alu_b_o,
  output logic                   alu_cin_o,
  output logic [1:0]             alu_op_o,
  input  logic [ALU_W-1:0]       alu_s_i,
  input  logic                   alu_cout_i
);

  localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic                   carry_q, carry_d;
  logic [WORDS*ALU_W-1:0] a_q,     a_d;
  logic [WORDS*ALU_W-1:0] b_q,     b_d;
  alu_op_t                op_q,    op_d;
  logic [WORDS*ALU_W-1:0] s_q,     s_d;

  logic [ALU_W-1:0]       word_a;
  logic [ALU_W-1:0]       word_b;

  alu_seq_word_mux #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_word_mux (
    .a_i      (a_q),
    .b_i      (b_q),
    .idx_i    (idx_q),
    .a_word_o (word_a),
    .b_word_o (word_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_OP_AND;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    s_d          = s_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_s_o     = s_q;
    resp_cout_o  = carry_q;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_cin_o    = 1'b0;
    alu_op_o     = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          a_d     = req_a_i;
          b_d     = req_b_i;
          op_d    = req_op_i;
          carry_d = req_cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        alu_a_o   = word_a;
        alu_b_o   = word_b;
        alu_cin_o = carry_q;
        alu_op_o  = op_q;
        // Carry is chained for logic ops too; the ALU ignores cin there.
        carry_d   = alu_cout_i;
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) begin
            s_d[w*ALU_W +: ALU_W] = alu_s_i;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        resp_valid_o = 1'b1;
`ifdef ALU_SEQ_B2B_EN
        req_ready_o  = resp_ready_i;
`endif
        if (resp_ready_i) begin
          state_d = IDLE;
`ifdef ALU_SEQ_B2B_EN
          // Response and next request share the edge: restart directly.
          if (req_valid_i) begin
            a_d     = req_a_i;
            b_d     = req_b_i;
            op_d    = req_op_i;
            carry_d = req_cin_i;
            idx_d   = '0;
            state_d = RUN;
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, whatever the state.
    if (rst) begin
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_s_o     = '0;
      resp_cout_o  = 1'b0;
      alu_a_o      = '0;
      alu_b_o      = '0;
      alu_cin_o    = 1'b0;
      alu_op_o     = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
//==============================================================================
// Module  : tb_alu_wide_sequencer
// Purpose : Self-checking bench for alu_wide_sequencer (WORDS=2) with a
//           behavioural 64-bit ALU on the alu_* ports.
// Config  : ALU_SEQ_B2B_EN selects the expected back-to-back response gap.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_wide_sequencer;
  import alu_seq_pkg::*;

  localparam int WORDS = 2;
  localparam int W     = WORDS * 64;
`ifdef ALU_SEQ_B2B_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic [1:0]   req_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_s;
  logic         resp_cout;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic         alu_cin;
  logic [1:0]   alu_op;
  logic [63:0]  alu_s;
  logic         alu_cout;
  logic [64:0]  alu_res;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_wide_sequencer #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_cin_i    (req_cin),
    .req_op_i     (req_op),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_s_o     (resp_s),
    .resp_cout_o  (resp_cout),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_cin_o    (alu_cin),
    .alu_op_o     (alu_op),
    .alu_s_i      (alu_s),
    .alu_cout_i   (alu_cout)
  );

  // Behavioural 64-bit ALU; logic ops report cout=0.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_OP_AND: alu_res = {1'b0, alu_a & alu_b};
      ALU_OP_OR:  alu_res = {1'b0, alu_a | alu_b};
      ALU_OP_ADD: alu_res = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_cin};
      default:    alu_res = {1'b0, alu_a} + {1'b0, ~alu_b} + {64'd0, alu_cin};
    endcase
  end
  assign alu_s    = alu_res[63:0];
  assign alu_cout = alu_res[64];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_rise = 0;
  int   rise_last = 0;
  int   rise_prev = 0;

  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic cin);
    case (op)
      ALU_OP_AND: return {1'b0, a & b};
      ALU_OP_OR:  return {1'b0, a | b};
      ALU_OP_ADD: return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      default:    return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; caller is just after a posedge. Returns cycle index
  // following the accept edge, or -1 if never accepted.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input bit push, input logic [W-1:0] es,
                      input logic ec, output int acc);
    exp_t e;
    bit   done;
    done      = 1'b0;
    acc       = -1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        acc  = cyc + 1;
        if (push) begin
          e.s    = es;
          e.cout = ec;
          sb.push_back(e);
        end
      end
      step();
    end
    req_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic wait_resp_valid(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_valid_timeout: got 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid && !prev) begin
        rise_prev = rise_last;
        rise_last = cyc;
        n_rise++;
      end
      prev = resp_valid;
      if (!rst && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got response s=%h expected none", resp_s);
        end else begin
          e = sb.pop_front();
          check("resp_s", resp_s, e.s);
          check("resp_cout", W'(resp_cout), W'(e.cout));
        end
      end
    end
  endtask

  initial begin
    int           acc;
    int           base;
    bit           seen;
    logic [W:0]   m;
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{ALU_OP_ADD, 128'h0000000000000000_FFFFFFFFFFFFFFFF, 128'h1, 1'b0,
                128'h1_0000000000000000, 1'b0};
    vecs[1] = '{ALU_OP_SUB, 128'h0, 128'h1, 1'b1, {128{1'b1}}, 1'b0};
    vecs[2] = '{ALU_OP_ADD, {128{1'b1}}, {128{1'b1}}, 1'b0, {{127{1'b1}}, 1'b0}, 1'b1};
    vecs[3] = '{ALU_OP_AND, {8{16'hF0F0}}, {8{16'hFF00}}, 1'b0, {8{16'hF000}}, 1'b0};
    vecs[4] = '{ALU_OP_OR,  {8{16'hF0F0}}, {8{16'h0F0F}}, 1'b1, {128{1'b1}}, 1'b0};
    vecs[5] = '{ALU_OP_ADD, 128'h0, 128'h0, 1'b1, 128'h1, 1'b0};
    vecs[6] = '{ALU_OP_SUB, 128'h5, 128'h7, 1'b1, {{126{1'b1}}, 2'b10}, 1'b0};
    vecs[7] = '{ALU_OP_SUB, 128'h7, 128'h5, 1'b1, 128'h2, 1'b1};
    vecs[8] = '{ALU_OP_ADD, 128'hFFFFFFFFFFFFFFFF_0000000000000000,
                128'h0000000000000001_0000000000000000, 1'b0, 128'h0, 1'b1};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = 1'b0;
    req_op     = '0;
    resp_ready = 1'b1;

    fork
      monitor();
    join_none

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  W'(req_ready),  '0);
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_s",     resp_s,         '0);
    check("rst_resp_cout",  W'(resp_cout),  '0);
    check("rst_alu_a",      W'(alu_a),      '0);
    check("rst_alu_b",      W'(alu_b),      '0);
    check("rst_alu_cin",    W'(alu_cin),    '0);
    check("rst_alu_op",     W'(alu_op),     '0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready",  W'(req_ready),  W'(1));
    check("idle_resp_valid", W'(resp_valid), '0);
    check("idle_alu_op",     W'(alu_op),     '0);
    step();

    // Latency from accept edge to resp_valid
    send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin, 1'b1, vecs[0].s, vecs[0].cout, acc);
    wait_resp_valid(seen);
    if (seen) check("latency", W'(cyc - acc), W'(2));
    drain();

    // Table of vectors
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, vecs[i].s, vecs[i].cout, acc);
      drain();
    end

    // Random vectors against the full-width model
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom, $urandom, $urandom, $urandom};
      rb  = {$urandom, $urandom, $urandom, $urandom};
      m   = model(rop, ra, rb, rop == ALU_OP_SUB);
      send(rop, ra, rb, rop == ALU_OP_SUB, 1'b1, m[W-1:0], m[W], acc);
      drain();
    end

    // Response held under back-pressure
    resp_ready = 1'b0;
    send(vecs[2].op, vecs[2].a, vecs[2].b, vecs[2].cin, 1'b1, vecs[2].s, vecs[2].cout, acc);
    wait_resp_valid(seen);
    for (int k = 0; k < 5 && seen; k++) begin
      if (k != 0) @(negedge clk);
      check("hold_resp_valid", W'(resp_valid), W'(1));
      check("hold_resp_s",     resp_s,         vecs[2].s);
      check("hold_resp_cout",  W'(resp_cout),  W'(vecs[2].cout));
      check("hold_req_ready",  W'(req_ready),  '0);
    end
    step();
    resp_ready = 1'b1;
    drain();

    // Reset during RUN at idx=1 aborts the operation
    send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin, 1'b0, vecs[0].s, vecs[0].cout, acc);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_alu_op",    W'(alu_op),    '0);
    check("abort_rst_req_ready", W'(req_ready), '0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_req_ready", W'(req_ready), W'(1));
    for (int k = 0; k < 3; k++) begin
      check("abort_resp_valid", W'(resp_valid), '0);
      @(negedge clk);
    end
    step();
    send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin, 1'b1, vecs[0].s, vecs[0].cout, acc);
    drain();

    // Two back-to-back requests: response spacing
    base = n_rise;
    send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin, 1'b1, vecs[0].s, vecs[0].cout, acc);
    send(vecs[7].op, vecs[7].a, vecs[7].b, vecs[7].cin, 1'b1, vecs[7].s, vecs[7].cout, acc);
    for (int k = 0; k < 40 && n_rise < base + 2; k++) @(negedge clk);
    if (n_rise >= base + 2) begin
      check("b2b_gap", W'(rise_last - rise_prev), W'(GAP));
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL b2b_gap: got %0d responses expected 2", n_rise - base);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
